branch_predict_unit: RTL
========================

Name: branch_predict_unit

Overview:
- Parametrised next-generation branch unit for the pipelined core.
- Predict side (fetch stage): direct-mapped branch target buffer (BTB) plus 2-bit saturating counters.
  - Given fetch_pc, returns pred_taken and pred_target the same cycle.
- Resolve side (execute stage): evaluates the branch condition, computes the target, compares against the prediction carried down the pipe, and updates the BTB.
- Raises a registered mispredict/redirect to the fetch unit one cycle after resolve.

Parameters:
- PC_W, 19, program counter width.
- OFF_W, 15, branch offset width; sign-extended to PC_W; must be <= PC_W.
- OPC_W, 5, opcode width.
- IDX_W, 4, BTB index bits; 2**IDX_W entries; index = pc[IDX_W-1:0], tag = pc[PC_W-1:IDX_W].

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_pc  in  PC_W  PC being fetched.
- pred_taken  out  1  combinational prediction for fetch_pc.
- pred_target  out  PC_W  predicted target; valid only when pred_taken=1, else 0.
- res_valid  in  1  resolve request this cycle.
- res_opcode  in  OPC_W  branch opcode.
- res_zero  in  1  zero flag.
- res_ovf_a  in  1  add overflow flag.
- res_ovf_s  in  1  subtract overflow flag.
- res_pc  in  PC_W  PC of the branch being resolved.
- res_offset  in  OFF_W  signed branch offset.
- res_pred_taken  in  1  prediction made at fetch for this instruction.
- res_pred_target  in  PC_W  target predicted at fetch.
- mispredict  out  1  registered; one-cycle pulse.
- redirect_pc  out  PC_W  registered; correct next PC, valid with mispredict.
- br_taken  out  1  registered actual outcome; valid with br_valid.
- br_valid  out  1  registered copy of res_valid.

Behaviour:
- Reset (async, rst_n=0):
  - All entry valid bits cleared; counters set to 2'b01 (weakly not-taken); tags and targets cleared to 0.
  - mispredict, redirect_pc, br_taken and br_valid all 0.
  - Reset mid-resolve drops that resolve: no update, no pulse.
- Branch conditions (non-branch opcodes give taken=0):
  - opcode 01010: taken=1 (unconditional).
  - opcode 01011: taken = res_zero | res_ovf_a.
  - opcode 01100: taken = ~res_zero | res_ovf_s.
- Branch classification: is_branch = opcode in {01010, 01011, 01100}.
- Arithmetic:
  - target = res_pc + sext(res_offset), modulo 2**PC_W (wrap-around, no overflow flag).
  - fallthrough = res_pc + 1, modulo 2**PC_W.
- Prediction (combinational, no state change):
  - Hit = entry valid and tag matches fetch_pc.
  - pred_taken = hit & counter[1].
  - pred_target = stored target when pred_taken=1, else 0.
- Resolve (res_valid=1, latency 1 cycle; outputs appear on the next rising edge):
  - br_valid<=1; br_taken<=taken.
  - Mispredict when is_branch and either:
    - taken != res_pred_taken, or
    - taken=1, res_pred_taken=1 and res_pred_target != target.
  - On mispredict: redirect_pc <= (taken ? target : fallthrough).
  - Non-branch opcode with res_pred_taken=1 (stale alias): mispredict=1, redirect_pc=fallthrough; entry invalidated.
  - No mispredict: mispredict<=0 and redirect_pc holds its previous value.
- BTB update (is_branch & res_valid, at the same edge):
  - Entry at res_pc index gets valid=1, tag and target written.
  - On tag match: counter saturating inc if taken, dec if not (00 floor, 11 ceiling).
  - On tag miss (replacement): counter initialised to 10 if taken, 01 if not.
- res_valid=0: br_valid<=0, mispredict<=0, BTB unchanged.
- Same-cycle lookup and update of the same index: lookup returns the pre-update entry (no bypass).
- Back-to-back resolves every cycle are supported at full throughput.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - Adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - stat_branches increments on each resolved is_branch; stat_mispredicts on each mispredict pulse.
  - Both wrap at 2**32 and reset to 0 with rst_n.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset cold predict: after reset, fetch_pc=0x00005 -> pred_taken=0, pred_target=0.
- Cold unconditional: resolve opcode 01010, res_pc=0x00010, offset=0x0008, pred_taken_in=0 -> next cycle mispredict=1, redirect_pc=0x00018, br_taken=1; then fetch_pc=0x00010 -> pred_taken=1, pred_target=0x00018.
- Backward branch wrap: opcode 01011, res_zero=1, res_pc=0x00002, offset=0x7FFC (-4) -> target=0x7FFFE, mispredict=1, redirect_pc=0x7FFFE.
- Counter hysteresis: resolve 01100 at pc 0x00020 taken, taken, not-taken (res_zero=1, res_ovf_s=0) -> counter 10->11->10, prediction stays taken; a fourth not-taken makes it 01 and pred_taken=0.
- False predicted-taken: res_pred_taken=1, opcode 01011, zero=0, ovf_a=0, res_pc=0x7FFFF -> mispredict=1, redirect_pc=0x00000 (fall-through wraps).
- Stats and reset: with BRANCH_STATS_EN, 5 branches with 2 mispredicts -> stat_branches=5, stat_mispredicts=2; assert rst_n low mid-resolve -> all outputs 0, counters 0.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Branch unit: direct-mapped BTB with 2-bit counters (predict) plus branch resolve/update.
// Latency: prediction is combinational; resolve outputs and BTB update land one cycle after res_valid.
// Backpressure: none; accepts a resolve every cycle. `define BRANCH_STATS_EN adds branch/mispredict counters.
module branch_predict_unit #(
  parameter int PC_W  = 19,
  parameter int OFF_W = 15,
  parameter int OPC_W = 5,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  fetch_pc,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             res_valid,
  input  logic [OPC_W-1:0] res_opcode,
  input  logic             res_zero,
  input  logic             res_ovf_a,
  input  logic             res_ovf_s,
  input  logic [PC_W-1:0]  res_pc,
  input  logic [OFF_W-1:0] res_offset,
  input  logic             res_pred_taken,
  input  logic [PC_W-1:0]  res_pred_target,
  output logic             mispredict,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             br_taken,
  output logic             br_valid
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts
`endif
);

  localparam int ENT   = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W;

  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(5'b01010);
  localparam logic [OPC_W-1:0] OP_BZO = OPC_W'(5'b01011);
  localparam logic [OPC_W-1:0] OP_BNZ = OPC_W'(5'b01100);

  // BTB storage
  logic             r_vld [ENT];
  logic [TAG_W-1:0] r_tag [ENT];
  logic [PC_W-1:0]  r_tgt [ENT];
  logic [1:0]       r_cnt [ENT];

  // Fetch-side lookup
  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic             w_f_hit;

  assign w_f_idx     = fetch_pc[IDX_W-1:0];
  assign w_f_tag     = fetch_pc[PC_W-1:IDX_W];
  assign w_f_hit     = r_vld[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign pred_taken  = w_f_hit & r_cnt[w_f_idx][1];
  assign pred_target = pred_taken ? r_tgt[w_f_idx] : '0;

  // Resolve-side datapath
  logic [IDX_W-1:0] w_r_idx;
  logic [TAG_W-1:0] w_r_tag;
  logic             w_r_hit;
  logic [1:0]       w_r_cnt;
  logic [PC_W-1:0]  w_off_sext;
  logic [PC_W-1:0]  w_target;
  logic [PC_W-1:0]  w_fall;
  logic             w_is_br;
  logic             w_taken;
  logic             w_mis;
  logic [1:0]       w_cnt_next;

  assign w_r_idx    = res_pc[IDX_W-1:0];
  assign w_r_tag    = res_pc[PC_W-1:IDX_W];
  assign w_r_hit    = r_vld[w_r_idx] && (r_tag[w_r_idx] == w_r_tag);
  assign w_r_cnt    = r_cnt[w_r_idx];
  assign w_off_sext = PC_W'($signed(res_offset));
  assign w_target   = res_pc + w_off_sext;
  assign w_fall     = res_pc + PC_W'(1);

  // Branch classification and condition evaluation
  always_comb begin
    w_is_br = 1'b0;
    w_taken = 1'b0;
    case (res_opcode)
      OP_JMP: begin w_is_br = 1'b1; w_taken = 1'b1; end
      OP_BZO: begin w_is_br = 1'b1; w_taken = res_zero | res_ovf_a; end
      OP_BNZ: begin w_is_br = 1'b1; w_taken = ~res_zero | res_ovf_s; end
      default: begin w_is_br = 1'b0; w_taken = 1'b0; end
    endcase
  end

  // A non-branch that was predicted taken is a stale BTB alias and must also redirect
  assign w_mis = res_valid &
                 ((w_is_br & ((w_taken != res_pred_taken) |
                              (w_taken & res_pred_taken & (res_pred_target != w_target)))) |
                  (~w_is_br & res_pred_taken));

  // Next counter: saturate on hit, seed weakly toward the outcome on replacement
  always_comb begin
    w_cnt_next = w_taken ? 2'b10 : 2'b01;
    if (w_r_hit) begin
      if (w_taken) w_cnt_next = (w_r_cnt == 2'b11) ? 2'b11 : w_r_cnt + 2'd1;
      else         w_cnt_next = (w_r_cnt == 2'b00) ? 2'b00 : w_r_cnt - 2'd1;
    end
  end

  // BTB update on resolved branches, invalidation on stale aliases
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENT; i++) begin
        r_vld[i] <= 1'b0;
        r_tag[i] <= '0;
        r_tgt[i] <= '0;
        r_cnt[i] <= 2'b01;
      end
    end else if (res_valid) begin
      if (w_is_br) begin
        r_vld[w_r_idx] <= 1'b1;
        r_tag[w_r_idx] <= w_r_tag;
        r_tgt[w_r_idx] <= w_target;
        r_cnt[w_r_idx] <= w_cnt_next;
      end else if (res_pred_taken) begin
        r_vld[w_r_idx] <= 1'b0;
      end
    end
  end

  // Registered resolve outputs; redirect_pc holds when there is no mispredict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      br_taken    <= 1'b0;
      br_valid    <= 1'b0;
    end else begin
      br_valid   <= res_valid;
      mispredict <= w_mis;
      if (res_valid) br_taken <= w_taken;
      if (w_mis) redirect_pc <= (w_is_br & w_taken) ? w_target : w_fall;
    end
  end

`ifdef BRANCH_STATS_EN
  // Free-running statistics, wrapping at 2**32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (res_valid & w_is_br) stat_branches <= stat_branches + 32'd1;
      if (w_mis) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule
